fetch_redirect_ctrl: RTL and testbench
======================================

// Module: fetch_redirect_ctrl
// PURPOSE
// Sequences the PC register: merges stall requests from IF/ID/MEM, ranks redirect sources
// (EX mispredict > ID prediction > sequential) and drives pc_reg's stall/failed/npc/pred ports.
// Holds a redirect that arrives while fetch is stalled and replays it once the stall clears.
// Raises pipeline flushes after a mispredict.
// PARAMETERS
// ADDR_W        32  PC/address width
// FLUSH_CYCLES  2   cycles flush_o stays high per mispredict (>=1)
// CNT_W         16  width of saturating mispredict counter
// PORTS
// clk            in   1       system clock
// rst_n          in   1       asynchronous active-low reset
// rdy            in   1       global enable; 0 freezes all state
// if_stall_req   in   1       icache/fetch busy
// id_stall_req   in   1       decode hazard stall
// mem_stall_req  in   1       memory stage busy
// ex_mispredict  in   1       EX detected wrong path (1-cycle pulse)
// ex_target      in   ADDR_W  correct PC for ex_mispredict
// id_pred_jump   in   1       ID predicts taken (1-cycle pulse)
// id_pred_pc     in   ADDR_W  predicted target
// pc_reg_stall   out  1       to pc_reg: hold PC
// failed_o       out  1       to pc_reg: take npc_o
// npc_o          out  ADDR_W  to pc_reg: mispredict target
// pred_jump_o    out  1       to pc_reg: take pred_pc_o
// pred_pc_o      out  ADDR_W  to pc_reg: predicted target
// flush_o        out  1       kill IF/ID and ID/EX contents
// mispred_cnt    out  CNT_W   saturating count of accepted mispredicts
// BEHAVIOUR
// - Reset (async, rst_n=0): state=RUN, pending cleared, flush counter 0, mispred_cnt 0;
//   all outputs 0 while in reset.
// - stall_any = if_stall_req|id_stall_req|mem_stall_req. pc_reg_stall = stall_any | ~rdy.
// - States: RUN (no pending), HOLD (redirect latched), FLUSH (flush counter nonzero, no pending).
// - RUN, stall_any=0: zero-latency pass-through, same cycle. ex_mispredict -> failed_o=1,
//   npc_o=ex_target, pred_jump_o=0. Else id_pred_jump -> pred_jump_o=1, pred_pc_o=id_pred_pc.
// - stall_any=1 and a redirect arrives: latch it (type + address), go HOLD; failed_o and
//   pred_jump_o stay 0 while stalled.
// - HOLD: a later ex_mispredict overwrites any pending entry (pending pred or mispredict).
//   A new id_pred_jump never overwrites a pending mispredict. On the first cycle with
//   stall_any=0, drive pending for exactly 1 cycle, then clear it. If a live ex_mispredict
//   arrives that same cycle, it wins and is driven instead; the pending entry is dropped.
// - Flush: on each accepted mispredict (live or latched), flush_o=1 that cycle; counter
//   loads FLUSH_CYCLES-1; flush_o holds while counter>0; counter decrements each rdy cycle.
//   A mispredict during FLUSH reloads the counter.
// - In FLUSH, id_pred_jump is ignored (wrong path); ex_mispredict is still honoured.
// - mispred_cnt: +1 per ex_mispredict pulse that is accepted (latched or driven), not per replay.
//   Saturates at all-ones.
// - rdy=0: no state, counter or pending change; failed_o=pred_jump_o=0; flush_o holds value;
//   input pulses in those cycles are ignored.
// - failed_o and pred_jump_o are never 1 in the same cycle.
// - Outputs during pass-through are combinational from inputs. Latched values and counters are flops.
// TESTING
// 1 Reset mid-HOLD (pending mispredict 0x100): rst_n low -> all outputs 0 immediately;
//   after release, no replay occurs.
// 2 RUN, no stall, ex_mispredict with ex_target=0x200 -> same cycle: failed_o=1, npc_o=0x200,
//   flush_o high 2 cycles, mispred_cnt=1.
// 3 mem_stall_req high 3 cycles; id_pred_jump 0x40 in cycle 1, ex_mispredict 0x80 in cycle 2
//   -> on stall drop: failed_o=1, npc_o=0x80 for 1 cycle; pred_jump_o never 1.
// 4 Same cycle: id_pred_jump 0x40 and ex_mispredict 0x300 -> failed_o=1, npc_o=0x300,
//   pred_jump_o=0.
// 5 During flush (counter=1): id_pred_jump -> ignored; ex_mispredict 0x500 -> failed_o=1,
//   flush extended 2 more cycles.
// 6 rdy=0 for 4 cycles while HOLD: pending kept, counter frozen. rdy=1 with no stall
//   -> replay in 1st cycle.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// PC redirect sequencer: merges stage stalls, ranks EX mispredict over ID prediction,
// parks a redirect that arrives during a stall and replays it, and times pipeline flushes.
module fetch_redirect_ctrl #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              if_stall_req,
   input  logic              id_stall_req,
   input  logic              mem_stall_req,
   input  logic              ex_mispredict,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic              id_pred_jump,
   input  logic [ADDR_W-1:0] id_pred_pc,
   output logic              pc_reg_stall,
   output logic              failed_o,
   output logic [ADDR_W-1:0] npc_o,
   output logic              pred_jump_o,
   output logic [ADDR_W-1:0] pred_pc_o,
   output logic              flush_o,
   output logic [CNT_W-1:0]  mispred_cnt
);

   localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0] FlushLoad = FW'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {StRun, StHold, StFlush} state_e;

   state_e              state_q, state_d;
   logic                pend_mis_q, pend_mis_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic [FW-1:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                stall_any, go, hold, in_flush, live_mis, live_pred, pend_valid_d;
   logic                fail, pj;
   logic [ADDR_W-1:0]   npc, ppc;

   always_comb begin
      stall_any    = if_stall_req | id_stall_req | mem_stall_req;
      go           = rdy & ~stall_any;
      hold         = (state_q == StHold);
      in_flush     = (fcnt_q != '0);
      live_mis     = rdy & ex_mispredict;
      // Predictions seen while a flush is running come from the wrong path.
      live_pred    = rdy & id_pred_jump & ~in_flush;
      fail         = 1'b0;
      pj           = 1'b0;
      npc          = '0;
      ppc          = '0;
      pend_valid_d = hold;
      pend_mis_d   = pend_mis_q;
      pend_addr_d  = pend_addr_q;

      if (go) begin
         pend_valid_d = 1'b0;
         if (live_mis) begin
            fail = 1'b1;
            npc  = ex_target;
         end else if (hold) begin
            if (pend_mis_q) begin
               fail = 1'b1;
               npc  = pend_addr_q;
            end else begin
               pj  = 1'b1;
               ppc = pend_addr_q;
            end
         end else if (live_pred) begin
            pj  = 1'b1;
            ppc = id_pred_pc;
         end
      end else if (rdy) begin
         if (live_mis) begin
            pend_valid_d = 1'b1;
            pend_mis_d   = 1'b1;
            pend_addr_d  = ex_target;
         end else if (live_pred && !(hold && pend_mis_q)) begin
            pend_valid_d = 1'b1;
            pend_mis_d   = 1'b0;
            pend_addr_d  = id_pred_pc;
         end
      end

      if (fail) begin
         fcnt_d = FlushLoad;
      end else if (rdy && in_flush) begin
         fcnt_d = fcnt_q - FW'(1);
      end else begin
         fcnt_d = fcnt_q;
      end

      cnt_d = (live_mis && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

      if (pend_valid_d) begin
         state_d = StHold;
      end else if (fcnt_d != '0) begin
         state_d = StFlush;
      end else begin
         state_d = StRun;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         pend_mis_q  <= 1'b0;
         pend_addr_q <= '0;
         fcnt_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pend_mis_q  <= pend_mis_d;
         pend_addr_q <= pend_addr_d;
         fcnt_q      <= fcnt_d;
         cnt_q       <= cnt_d;
      end
   end

   // Outputs are forced low while reset is asserted, even with live stall inputs.
   always_comb begin
      pc_reg_stall = rst_n & (stall_any | ~rdy);
      failed_o     = rst_n & fail;
      npc_o        = rst_n ? npc : '0;
      pred_jump_o  = rst_n & pj;
      pred_pc_o    = rst_n ? ppc : '0;
      flush_o      = rst_n & (fail | in_flush);
      mispred_cnt  = cnt_q;
   end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Table-driven, scoreboard-checked bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, rdy, if_s, id_s, mem_s, mis, pj_i;
   logic [31:0] tgt, ppc_i;
   logic        pc_reg_stall, failed_o, pred_jump_o, flush_o;
   logic [31:0] npc_o, pred_pc_o;
   logic [15:0] mispred_cnt;

   typedef struct packed {
      logic        stall;
      logic        fail;
      logic [31:0] npc;
      logic        pj;
      logic [31:0] ppc;
      logic        flush;
      logic [15:0] cnt;
   } out_t;

   typedef struct {
      logic        rdy;
      logic [2:0]  st;   // {if, id, mem}
      logic        mis;
      logic [31:0] tgt;
      logic        pj;
      logic [31:0] ppc;
      out_t        exp;
   } vec_t;

   vec_t vecs[$];
   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   fetch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rdy           (rdy),
      .if_stall_req  (if_s),
      .id_stall_req  (id_s),
      .mem_stall_req (mem_s),
      .ex_mispredict (mis),
      .ex_target     (tgt),
      .id_pred_jump  (pj_i),
      .id_pred_pc    (ppc_i),
      .pc_reg_stall  (pc_reg_stall),
      .failed_o      (failed_o),
      .npc_o         (npc_o),
      .pred_jump_o   (pred_jump_o),
      .pred_pc_o     (pred_pc_o),
      .flush_o       (flush_o),
      .mispred_cnt   (mispred_cnt)
   );

   always #5 clk = ~clk;

   function automatic out_t cur();
      out_t o;
      o = '{stall: pc_reg_stall, fail: failed_o, npc: npc_o, pj: pred_jump_o,
            ppc: pred_pc_o, flush: flush_o, cnt: mispred_cnt};
      return o;
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = cur();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got stall=%0b fail=%0b npc=%h pj=%0b ppc=%h flush=%0b cnt=%0d, want stall=%0b fail=%0b npc=%h pj=%0b ppc=%h flush=%0b cnt=%0d",
                  name, act.stall, act.fail, act.npc, act.pj, act.ppc, act.flush, act.cnt,
                  exp.stall, exp.fail, exp.npc, exp.pj, exp.ppc, exp.flush, exp.cnt);
      end
   endtask

   task automatic add(input logic r, input logic [2:0] st, input logic m, input logic [31:0] t,
                      input logic p, input logic [31:0] pc, input logic es, input logic ef,
                      input logic [31:0] en, input logic ep, input logic [31:0] epc,
                      input logic efl, input logic [15:0] ec);
      vec_t v;
      v.rdy = r; v.st = st; v.mis = m; v.tgt = t; v.pj = p; v.ppc = pc;
      v.exp = '{stall: es, fail: ef, npc: en, pj: ep, ppc: epc, flush: efl, cnt: ec};
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      rdy = 1'b1; if_s = 1'b0; id_s = 1'b0; mem_s = 1'b0;
      mis = 1'b0; tgt = '0; pj_i = 1'b0; ppc_i = '0;
   endtask

   out_t zero;

   initial begin
      zero = '0;
      rst_n = 1'b0;
      idle_inputs();

      //   rdy  if/id/mem mis tgt     pj ppc      | stl fail npc     pj ppc     fl cnt
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 0);
      add(1, 3'b000, 1, 'h200,   0, 0,        0, 1, 'h200,   0, 0,       1, 0);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       1, 1);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 1);
      add(1, 3'b000, 0, 0,       1, 'h1000,   0, 0, 0,       1, 'h1000,  0, 1);
      // mem stall 3 cycles: pred then mispredict, replay of the mispredict
      add(1, 3'b001, 0, 0,       1, 'h40,     1, 0, 0,       0, 0,       0, 1);
      add(1, 3'b001, 1, 'h80,    0, 0,        1, 0, 0,       0, 0,       0, 1);
      add(1, 3'b001, 0, 0,       0, 0,        1, 0, 0,       0, 0,       0, 2);
      add(1, 3'b000, 0, 0,       0, 0,        0, 1, 'h80,    0, 0,       1, 2);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       1, 2);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 2);
      // simultaneous pred and mispredict
      add(1, 3'b000, 1, 'h300,   1, 'h40,     0, 1, 'h300,   0, 0,       1, 2);
      // pred during flush ignored
      add(1, 3'b000, 0, 0,       1, 'h44,     0, 0, 0,       0, 0,       1, 3);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 3);
      // mispredict during flush reloads the counter
      add(1, 3'b000, 1, 'h5f0,   0, 0,        0, 1, 'h5f0,   0, 0,       1, 3);
      add(1, 3'b000, 1, 'h500,   0, 0,        0, 1, 'h500,   0, 0,       1, 4);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       1, 5);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 5);
      // HOLD frozen by rdy=0, pulses ignored, replay on first ready unstalled cycle
      add(1, 3'b100, 1, 'h600,   0, 0,        1, 0, 0,       0, 0,       0, 5);
      add(0, 3'b000, 1, 'h700,   0, 0,        1, 0, 0,       0, 0,       0, 6);
      add(0, 3'b000, 0, 0,       1, 'h704,    1, 0, 0,       0, 0,       0, 6);
      add(0, 3'b000, 1, 'h708,   0, 0,        1, 0, 0,       0, 0,       0, 6);
      add(0, 3'b000, 0, 0,       0, 0,        1, 0, 0,       0, 0,       0, 6);
      add(1, 3'b000, 0, 0,       0, 0,        0, 1, 'h600,   0, 0,       1, 6);
      // flush counter frozen by rdy=0
      add(0, 3'b000, 0, 0,       0, 0,        1, 0, 0,       0, 0,       1, 6);
      add(0, 3'b000, 0, 0,       0, 0,        1, 0, 0,       0, 0,       1, 6);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       1, 6);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 6);
      // pending prediction replays exactly once
      add(1, 3'b010, 0, 0,       1, 'h900,    1, 0, 0,       0, 0,       0, 6);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       1, 'h900,   0, 6);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 6);
      // pred cannot overwrite a pending mispredict
      add(1, 3'b010, 1, 'ha00,   0, 0,        1, 0, 0,       0, 0,       0, 6);
      add(1, 3'b010, 0, 0,       1, 'hb00,    1, 0, 0,       0, 0,       0, 7);
      add(1, 3'b000, 0, 0,       0, 0,        0, 1, 'ha00,   0, 0,       1, 7);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       1, 7);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 7);
      // live mispredict beats a pending pred; pending dropped
      add(1, 3'b100, 0, 0,       1, 'hc00,    1, 0, 0,       0, 0,       0, 7);
      add(1, 3'b000, 1, 'hd00,   0, 0,        0, 1, 'hd00,   0, 0,       1, 7);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       1, 8);
      add(1, 3'b000, 0, 0,       0, 0,        0, 0, 0,       0, 0,       0, 8);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", zero);

      for (int i = 0; i < vecs.size(); i++) begin
         out_t e;
         @(posedge clk);
         #1;
         rdy = vecs[i].rdy; {if_s, id_s, mem_s} = vecs[i].st;
         mis = vecs[i].mis; tgt = vecs[i].tgt; pj_i = vecs[i].pj; ppc_i = vecs[i].ppc;
         sb.push_back(vecs[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         check($sformatf("vec%0d", i), e);
      end

      // Reset while a mispredict is pending: outputs drop at once, no replay afterwards
      @(posedge clk);
      #1 idle_inputs(); mem_s = 1'b1; mis = 1'b1; tgt = 32'h100;
      @(posedge clk);
      #1 mis = 1'b0; tgt = '0;
      #2 rst_n = 1'b0;
      #1 check("reset_mid_hold", zero);
      @(posedge clk);
      #1 rst_n = 1'b1; mem_s = 1'b0;
      @(negedge clk);
      check("no_replay_after_reset_0", zero);
      @(posedge clk);
      @(negedge clk);
      check("no_replay_after_reset_1", zero);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
